// File: rtl/color_ram_arbiter_pkg.sv
// Shared types and widths for the palette RAM arbiter and its write FIFO.
package color_ram_arbiter_pkg;

    localparam int COLOR_W     = 12;
    localparam int COLOR_IDX_W = 5;
    localparam int RAM_DEPTH   = 1 << COLOR_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [COLOR_IDX_W-1:0] idx;
        logic [COLOR_W-1:0]     rgb;
    } fifo_entry_t;

endpackage

// File: rtl/color_wr_fifo.sv
// Pending COLORxx write queue; exposes every slot (oldest first) so reads can snoop it.
module color_wr_fifo
    import color_ram_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push_i,
    input  fifo_entry_t                 entry_i,
    input  logic                        pop_i,
    output logic                        full_o,
    output logic                        empty_o,
    output fifo_entry_t                 head_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output fifo_entry_t [DEPTH-1:0]     entries_o,
    output logic [DEPTH-1:0]            valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fifo_entry_t    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           push_ok;
    logic           pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is still accepted when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry_i;
    end

    always_comb begin
        logic [PW-1:0] slot;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot         = rd_ptr_q + PW'(i);
            entries_o[i] = mem_q[slot];
            valid_o[i]   = (CW'(i) < count_q);
        end
    end

endmodule

// File: rtl/color_ram_arbiter.sv
// Single-port palette RAM shared between pixel lookups and queued COLORxx writes.
// Optional COLOR_BYPASS_EN: lookups see the youngest pending write to the same index.
module color_ram_arbiter
    import color_ram_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   color_en,
    input  logic [COLOR_IDX_W-1:0] color_idx,
    input  logic [COLOR_W-1:0]     db_in,
    input  logic                   pix_req,
    input  logic [COLOR_IDX_W-1:0] pix_idx,
    output logic [COLOR_W-1:0]     pix_rgb,
    output logic                   pix_valid,
    output logic                   pix_stale,
    output logic                   ovf
);

    localparam int WAIT_W = $clog2(STARVE_MAX + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    arb_state_t                  state_q, state_d;
    logic [WAIT_W-1:0]           wait_q, wait_d;
    logic [COLOR_W-1:0]          pix_rgb_q;
    logic                        pix_valid_q;
    logic                        pix_stale_q;
    logic                        ovf_q;

    logic [COLOR_W-1:0]          ram_q [RAM_DEPTH];
    logic [COLOR_W-1:0]          rd_data;
    logic                        do_read;
    logic                        do_write;
    logic                        stale_d;
    logic                        last_entry;

    fifo_entry_t                 wr_entry;
    fifo_entry_t                 fifo_head;
    fifo_entry_t [FIFO_DEPTH-1:0] fifo_entries;
    logic [FIFO_DEPTH-1:0]       fifo_valid;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        unused_fifo;

    assign wr_entry.idx = color_idx;
    assign wr_entry.rgb = db_in;

    color_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (color_en),
        .entry_i   (wr_entry),
        .pop_i     (do_write),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .count_o   (fifo_count),
        .entries_o (fifo_entries),
        .valid_o   (fifo_valid)
    );

    assign unused_fifo = ^{fifo_empty, fifo_entries, fifo_valid};

    // The queue empties this cycle if its only entry is written and nothing new arrives.
    assign last_entry = (fifo_count == CNT_W'(1)) && !color_en;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        do_read  = 1'b0;
        do_write = 1'b0;
        stale_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                do_read = pix_req;
                wait_d  = '0;
                if (color_en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pix_req) begin
                    do_read = 1'b1;
                    if (wait_q < WAIT_W'(STARVE_MAX)) wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_W'(STARVE_MAX)) state_d = ST_FORCE;
                end else begin
                    do_write = 1'b1;
                    wait_d   = '0;
                    if (last_entry) state_d = ST_IDLE;
                end
            end
            ST_FORCE: begin
                do_write = 1'b1;
                stale_d  = pix_req;
                wait_d   = '0;
                state_d  = last_entry ? ST_IDLE : ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
    end

`ifdef COLOR_BYPASS_EN
    // Slots are ordered oldest first, so the last match is the youngest pending write.
    always_comb begin
        rd_data = ram_q[pix_idx];
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_entries[i].idx == pix_idx)) rd_data = fifo_entries[i].rgb;
        end
    end
`else
    assign rd_data = ram_q[pix_idx];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            pix_rgb_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_stale_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            pix_valid_q <= do_read;
            pix_stale_q <= stale_d;
            if (do_read) pix_rgb_q <= rd_data;
            if (color_en && fifo_full && !do_write) ovf_q <= 1'b1;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (do_write) ram_q[fifo_head.idx] <= fifo_head.rgb;
    end

    assign pix_rgb   = pix_rgb_q;
    assign pix_valid = pix_valid_q;
    assign pix_stale = pix_stale_q;
    assign ovf       = ovf_q;

endmodule
